// File: rtl/ebus_diag_master.sv
// EBUS diagnostic-function initiator: issues one ds/diagStrobe transaction per req.
// Optional read parity checking is enabled by defining EBUS_DIAG_PARITY_EN.
module ebus_diag_master #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        req,
  input  logic [0:6]  func,
  input  logic [0:35] wdata,
  output logic        busy,
  output logic        done,
  output logic [0:35] rdata,
  output logic        perr,
  output logic [0:6]  ebus_ds,
  output logic        ebus_strobe,
  output logic        ebus_drive,
  output logic [0:35] ebus_dout,
  input  logic [0:35] ebus_din,
  input  logic        ebus_par_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [0:6]  func_q;
  logic [0:35] wdata_q;
  logic        active;
  logic        capture;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (req) begin
          state_nx = S_SETUP;
          cnt_nx   = 8'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nx = S_STROBE;
          cnt_nx   = 8'(STROBE_CYC - 1);
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt == '0) begin
          state_nx = S_HOLD;
          cnt_nx   = 8'(HOLD_CYC - 1);
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          state_nx = S_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      func_q  <= '0;
      wdata_q <= '0;
    end else if (state == S_IDLE && req) begin
      func_q  <= func;
      wdata_q <= wdata;
    end
  end

  // Read data is sampled on the edge that closes the final strobe cycle.
  assign capture = (state == S_STROBE) && (cnt == '0) && func_q[0];

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rdata <= '0;
    end else if (capture) begin
      rdata <= ebus_din;
    end
  end

`ifdef EBUS_DIAG_PARITY_EN
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      perr <= 1'b0;
    end else if (capture) begin
      perr <= ~(^ebus_din ^ ebus_par_in);
    end
  end
`else
  logic unused_par;
  assign unused_par = ebus_par_in;
  assign perr       = 1'b0;
`endif

  // Bus outputs decode directly from state so reset removes them immediately.
  always_comb begin
    active      = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    ebus_ds     = active ? func_q : '0;
    ebus_strobe = (state == S_STROBE);
    ebus_drive  = active && !func_q[0];
    ebus_dout   = (active && !func_q[0]) ? wdata_q : '0;
  end

endmodule

// File: tb/tb_ebus_diag_master.sv
// Scoreboard bench for ebus_diag_master; honours EBUS_DIAG_PARITY_EN if defined.
module tb_ebus_diag_master;

  logic        clk = 1'b0;
  logic        RESET;
  logic        req;
  logic [0:6]  func;
  logic [0:35] wdata;
  logic        busy, done, perr;
  logic [0:35] rdata;
  logic [0:6]  ebus_ds;
  logic        ebus_strobe, ebus_drive;
  logic [0:35] ebus_dout;
  logic [0:35] ebus_din;
  logic        ebus_par_in;

  typedef struct {
    logic [0:35] rdata;
    logic        perr;
  } exp_t;

  exp_t        sb[$];
  logic [0:35] m_rdata;
  logic        m_perr;
  int          checks   = 0;
  int          failures = 0;

  ebus_diag_master #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(2)) dut (
    .clk(clk), .RESET(RESET), .req(req), .func(func), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .perr(perr),
    .ebus_ds(ebus_ds), .ebus_strobe(ebus_strobe), .ebus_drive(ebus_drive),
    .ebus_dout(ebus_dout), .ebus_din(ebus_din), .ebus_par_in(ebus_par_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_txn(input logic [0:6] f, input logic [0:35] wd,
                         input logic [0:35] din_s, input logic [0:35] din_h,
                         input logic par, input int pulse_at, input bit hold_req);
    exp_t        e;
    exp_t        got;
    logic [0:6]  x_ds;
    logic        x_drv;
    func        = f;
    wdata       = wd;
    ebus_din    = din_s;
    ebus_par_in = par;
    req         = 1'b1;
    if (f[0]) begin
      m_rdata = din_s;
`ifdef EBUS_DIAG_PARITY_EN
      m_perr = ~(^din_s ^ par);
`endif
    end
    e.rdata = m_rdata;
    e.perr  = m_perr;
    sb.push_back(e);
    @(posedge clk); #1;
    if (!hold_req) req = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (k == 7) ebus_din = din_h;
      if (k == pulse_at) req = 1'b1;
      if (pulse_at > 0 && k == pulse_at + 1) req = 1'b0;
      x_ds  = (k <= 8) ? f : 7'o0;
      x_drv = (k <= 8) && !f[0];
      check($sformatf("busy_c%0d", k), 64'(busy), 64'(k <= 9));
      check($sformatf("done_c%0d", k), 64'(done), 64'(k == 9));
      check($sformatf("ds_c%0d", k), 64'(ebus_ds), 64'(x_ds));
      check($sformatf("strobe_c%0d", k), 64'(ebus_strobe), 64'(k >= 3 && k <= 6));
      check($sformatf("drive_c%0d", k), 64'(ebus_drive), 64'(x_drv));
      check($sformatf("dout_c%0d", k), 64'(ebus_dout), x_drv ? 64'(wd) : 64'd0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 64'(done), 64'd0);
        end else begin
          got = sb.pop_front();
          check("rdata", 64'(rdata), 64'(got.rdata));
          check("perr", 64'(perr), 64'(got.perr));
        end
      end
    end
  endtask

  initial begin
    logic [0:35] wd;
    RESET = 1'b1; req = 1'b0; func = '0; wdata = '0;
    ebus_din = '0; ebus_par_in = 1'b0;
    m_rdata = '0; m_perr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ds", 64'(ebus_ds), 64'd0);
    check("rst_strobe", 64'(ebus_strobe), 64'd0);
    check("rst_drive", 64'(ebus_drive), 64'd0);
    check("rst_dout", 64'(ebus_dout), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    check("rst_perr", 64'(perr), 64'd0);
    @(negedge clk) RESET = 1'b0;

    // Load 076 with a marker in bits 24..28
    wd = '0;
    wd[24:28] = 5'b10110;
    run_txn(7'o076, wd, 36'o0, 36'o0, 1'b0, 0, 1'b0);
    // Reads: plain, a different value, then bus dropping to 0 in HOLD
    run_txn(7'o100, 36'o0, 36'o123456701234, 36'o123456701234, 1'b0, 0, 1'b0);
    run_txn(7'o100, 36'o0, 36'o777000111222, 36'o777000111222, 1'b1, 0, 1'b0);
    run_txn(7'o100, 36'o0, 36'o123456701234, 36'o0, 1'b0, 0, 1'b0);
    // Load leaves rdata alone; req pulse mid-transaction is ignored
    run_txn(7'o040, 36'o525252525252, 36'o777777777777, 36'o777777777777, 1'b0, 4, 1'b0);
    // req held through DONE: next transaction accepted after one IDLE cycle
    run_txn(7'o041, 36'o000000000017, 36'o0, 36'o0, 1'b0, 0, 1'b1);
    run_txn(7'o177, 36'o0, 36'o400000000001, 36'o400000000001, 1'b1, 0, 1'b0);
    run_txn(7'o000, 36'o111111111111, 36'o0, 36'o0, 1'b0, 0, 1'b0);

    // Reset in the middle of STROBE
    func = 7'o076; wdata = 36'o707070707070; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_abort_strobe", 64'(ebus_strobe), 64'd1);
    RESET = 1'b1;
    #1;
    check("abort_ds", 64'(ebus_ds), 64'd0);
    check("abort_strobe", 64'(ebus_strobe), 64'd0);
    check("abort_drive", 64'(ebus_drive), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    m_rdata = '0;
    m_perr  = 1'b0;
    check("abort_rdata", 64'(rdata), 64'd0);
    @(negedge clk) RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_abort_done", 64'(done), 64'd0);
      check("post_abort_busy", 64'(busy), 64'd0);
    end
    run_txn(7'o070, 36'o123123123123, 36'o0, 36'o0, 1'b0, 0, 1'b0);

    // Parity on read
    run_txn(7'o100, 36'o0, 36'o1, 36'o1, 1'b1, 0, 1'b0);
    run_txn(7'o100, 36'o0, 36'o1, 36'o1, 1'b0, 0, 1'b0);
    run_txn(7'o100, 36'o0, 36'o3, 36'o3, 1'b0, 0, 1'b0);
    run_txn(7'o010, 36'o5, 36'o0, 36'o0, 1'b0, 0, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
